// File: rtl/dcache_miss_sched_pkg.sv
// Shared encodings for the dcache miss scheduler: request kinds, FSM
// states, the cache line geometry and the bridge burst/single type values.
package dcache_miss_sched_pkg;

  localparam int LINE_OFF_W = 5;

  localparam logic TYPE_LINE   = 1'b1;
  localparam logic TYPE_SINGLE = 1'b0;

  localparam logic [1:0] KIND_REFILL = 2'b00;
  localparam logic [1:0] KIND_UC_LD  = 2'b01;
  localparam logic [1:0] KIND_UC_ST  = 2'b10;
  localparam logic [1:0] KIND_RSVD   = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WB   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

endpackage

// File: rtl/dcache_miss_sched.sv
// dcache miss scheduler: serialises one refill / uncached access at a time
// onto the bridge read and write ports and returns one completion pulse.
// Optional build macro DCACHE_STRICT_WB_ORDER_EN: a dirty refill waits in WB
// for the victim write response before issuing the line read.
module dcache_miss_sched #(
  parameter int   LINE_OFF_W = dcache_miss_sched_pkg::LINE_OFF_W,
  parameter logic LINE_LEN   = dcache_miss_sched_pkg::TYPE_LINE
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_kind,
  input  logic [31:0]  req_addr,
  input  logic [2:0]   req_size,
  input  logic [3:0]   req_wstrb,
  input  logic [31:0]  req_wdata,
  input  logic         req_dirty,
  input  logic [31:0]  victim_addr,
  input  logic [255:0] victim_data,
  output logic         resp_valid,
  output logic [255:0] resp_data,
  output logic         rd_req,
  output logic         rd_type,
  output logic [31:0]  rd_addr,
  output logic [2:0]   rd_size,
  input  logic         rd_rdy,
  input  logic         ret_valid,
  input  logic [255:0] ret_data,
  output logic         wr_req,
  output logic         wr_type,
  output logic [31:0]  wr_addr,
  output logic [2:0]   wr_size,
  output logic [3:0]   wr_wstrb,
  output logic [255:0] wr_data,
  input  logic         wr_rdy,
  input  logic         wr_ok
);
  import dcache_miss_sched_pkg::*;

  localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFF_W) - 32'd1);

  logic [2:0]   state;
  logic [1:0]   kind_q;
  logic [31:0]  addr_q;
  logic [2:0]   size_q;
  logic [3:0]   wstrb_q;
  logic [31:0]  wdata_q;
  logic [31:0]  vaddr_q;
  logic [255:0] vdata_q;
  logic         rd_pend;
  logic         wr_pend;
  logic         is_refill;

  // Handshake outputs are pure state decodes; no input-to-output paths.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign rd_req     = (state == S_RD);
  assign wr_req     = (state == S_WB) && !wr_pend;

  assign is_refill  = (kind_q == KIND_REFILL);

  // Bridge command fields come straight from the latched request.
  always_comb begin
    rd_type  = is_refill ? LINE_LEN : TYPE_SINGLE;
    rd_addr  = is_refill ? (addr_q & LINE_MASK) : addr_q;
    rd_size  = is_refill ? 3'd2 : size_q;
    wr_type  = is_refill ? LINE_LEN : TYPE_SINGLE;
    wr_addr  = is_refill ? (vaddr_q & LINE_MASK) : addr_q;
    wr_size  = is_refill ? 3'd2 : size_q;
    wr_wstrb = is_refill ? 4'hF : wstrb_q;
    wr_data  = is_refill ? vdata_q : {224'b0, wdata_q};
  end

  // Miss FSM with read/write pending flags; bridge pulses are honoured in
  // any state where the matching flag is set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      kind_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      vaddr_q   <= '0;
      vdata_q   <= '0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      resp_data <= '0;
    end else begin
      // A write response with nothing outstanding is a no-op.
      if (wr_ok) wr_pend <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          kind_q  <= req_kind;
          addr_q  <= req_addr;
          size_q  <= req_size;
          wstrb_q <= req_wstrb;
          wdata_q <= req_wdata;
          vaddr_q <= victim_addr;
          vdata_q <= victim_data;
          case (req_kind)
            KIND_REFILL: state <= req_dirty ? S_WB : S_RD;
            KIND_UC_LD:  state <= S_RD;
            KIND_UC_ST:  state <= S_WB;
            default: begin
              resp_data <= '0;
              state     <= S_RESP;
            end
          endcase
        end
        S_WB: begin
          if (!wr_pend && wr_rdy) begin
            wr_pend <= 1'b1;
`ifdef DCACHE_STRICT_WB_ORDER_EN
            if (!is_refill) state <= S_WAIT;
`else
            state <= is_refill ? S_RD : S_WAIT;
`endif
          end
`ifdef DCACHE_STRICT_WB_ORDER_EN
          // Victim write acknowledged: the line read may now go out.
          if (wr_pend && wr_ok) state <= S_RD;
`endif
        end
        S_RD: if (rd_rdy) begin
          state <= S_WAIT;
          // Data returned in the handshake cycle itself is captured here.
          if (ret_valid)
            resp_data <= is_refill ? ret_data : {224'b0, ret_data[31:0]};
          else
            rd_pend <= 1'b1;
        end
        S_WAIT: begin
          if (ret_valid && rd_pend) begin
            rd_pend   <= 1'b0;
            resp_data <= is_refill ? ret_data : {224'b0, ret_data[31:0]};
          end
          if ((!rd_pend || ret_valid) && (!wr_pend || wr_ok)) state <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_miss_sched.md
Name: dcache_miss_sched

Overview:
- Sequences the dcache's miss traffic onto the bridge's dcache read and write ports.
- Handles three request kinds:
  - Cached refill, with an optional dirty-victim writeback.
  - Uncached load.
  - Uncached store.
- Sits between the dcache miss logic and the AXI bridge.
- Serialises one miss at a time and returns a single completion pulse to the cache.

Parameters:
- LINE_OFF_W, 5, byte-offset bits of a cache line (32 B line = 8 words).
- LINE_LEN, 1, bridge rd_type/wr_type value selecting an 8-word burst.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  miss request from dcache
- req_ready  out  1  scheduler can accept a request
- req_kind  in  2  00 cached refill, 01 uncached load, 10 uncached store, 11 reserved
- req_addr  in  32  miss or uncached address
- req_size  in  3  uncached access size (log2 bytes)
- req_wstrb  in  4  uncached store byte strobes
- req_wdata  in  32  uncached store data
- req_dirty  in  1  victim line dirty (cached refill only)
- victim_addr  in  32  victim line address
- victim_data  in  256  victim line data
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  256  refill line, or uncached load word in bits [31:0]
- rd_req  out  1  bridge read request
- rd_type  out  1  1 = line burst, 0 = single word
- rd_addr  out  32  bridge read address
- rd_size  out  3  bridge read size
- rd_rdy  in  1  bridge read accept
- ret_valid  in  1  bridge read return pulse
- ret_data  in  256  bridge read data
- wr_req  out  1  bridge write request
- wr_type  out  1  1 = line burst, 0 = single word
- wr_addr  out  32  bridge write address
- wr_size  out  3  bridge write size
- wr_wstrb  out  4  bridge write strobes
- wr_data  out  256  bridge write data
- wr_rdy  in  1  bridge write accept
- wr_ok  in  1  bridge write-response pulse

Behaviour:
- Reset is resetn (synchronous, active-low) on clk.
- Reset values:
  - State is IDLE.
  - req_ready=1.
  - resp_valid, rd_req and wr_req are 0.
  - All latched address, data and control registers are 0.
- States: IDLE, WB, RD, WAIT, RESP.
- req_ready=1 only in IDLE.
- Request acceptance: a request is accepted on req_valid&&req_ready. All request fields are latched that cycle.
- Transitions out of IDLE on acceptance:
  - Refill with req_dirty=1 → WB.
  - Refill with req_dirty=0 → RD.
  - Uncached load → RD.
  - Uncached store → WB.
  - Kind 11 → RESP with resp_data=0; nothing is issued to the bridge.
- WB:
  - wr_req=1 is held until wr_rdy.
  - Refill writeback fields: wr_type=LINE_LEN, wr_addr=victim_addr with the low LINE_OFF_W bits cleared, wr_size=2, wr_wstrb=4'hF, wr_data=victim_data.
  - Uncached store fields: wr_type=0, wr_addr=req_addr, wr_size=req_size, wr_wstrb=req_wstrb, wr_data={224'b0, req_wdata}.
  - On handshake, wr_pend is set. Next state is RD for a refill, WAIT for a store.
- RD:
  - rd_req=1 is held until rd_rdy.
  - Refill fields: rd_type=LINE_LEN, rd_addr=req_addr with the low LINE_OFF_W bits cleared, rd_size=2.
  - Uncached load fields: rd_type=0, rd_addr=req_addr, rd_size=req_size.
  - On handshake, rd_pend is set and the next state is WAIT.
- WAIT:
  - ret_valid clears rd_pend and captures ret_data into resp_data.
  - wr_ok clears wr_pend.
  - ret_valid and wr_ok in the same cycle are both honoured.
  - A pulse arriving in the same cycle as the RD handshake is honoured, so it is never lost.
  - When both rd_pend and wr_pend are 0, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_data holds its value until the next capture.
- rd_req and wr_req are never asserted in the same cycle.
- ret_valid or wr_ok arriving while nothing is pending is ignored.
- Reset mid-operation: everything returns to IDLE immediately. The bridge shares resetn, so no stale responses survive.
- Minimum latency, clean refill: accept at T0 → rd_req at T1 → WAIT at T2 → ret at Tn → resp_valid at Tn+1.

Optional Feature:
- Macro: DCACHE_STRICT_WB_ORDER_EN.
- Defined: a dirty refill stays in WB until wr_ok is received (wr_pend cleared), then moves to RD. The refill read never overtakes the victim writeback at the slave.
- Undefined: RD follows immediately after the WB handshake, as specified above.

Decomposition:
- Shared package holds:
  - req_kind encodings (KIND_REFILL, KIND_UC_LD, KIND_UC_ST).
  - State encodings.
  - LINE_OFF_W.
  - The burst and single type constants.
- No sub-module; a single FSM with two pending flags.

Test Plan:
- Clean refill of 0x1000_0024, rd_rdy immediate, ret 6 cycles later → rd_addr=0x1000_0020, rd_type=1, rd_size=2; resp_valid exactly one cycle later carrying ret_data.
- Dirty refill, victim 0x2000_0040, wr_ok arrives 3 cycles after ret_valid → wr_req precedes rd_req; resp_valid one cycle after wr_ok, not after ret_valid.
- Uncached store to 0xBFD0_0004, size 0, wstrb 4'b0001, data 0xAB → wr_type=0, wr_data[31:0]=0xAB, no rd_req; resp_valid one cycle after wr_ok.
- Uncached load with rd_rdy held low 4 cycles → rd_req stays high and rd_addr stable throughout; resp_data[31:0]=ret_data[31:0].
- ret_valid and wr_ok in the same cycle during a dirty refill → a single resp_valid the next cycle.
- resetn low while in WAIT → next cycle IDLE, req_ready=1, resp_valid never pulses.
- With DCACHE_STRICT_WB_ORDER_EN defined, run the dirty-refill scenario → rd_req is not asserted before wr_ok.
